// File: rtl/fixdiv_seq.sv
// Sequential signed fixed-point divider: restoring shift-subtract on magnitudes,
// round-half-up (ties toward +inf) and saturation to the programmed output format.
module fixdiv_seq #(
  parameter int unsigned DW = 36,
  parameter int unsigned DF = 27,
  parameter int unsigned VW = 15,
  parameter int unsigned VF = 11,
  parameter int unsigned QW = 36,
  parameter int unsigned QF = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  output logic [QW-1:0] quotient,
  output logic          ovf,
  output logic          dz,
  output logic          busy
);

  localparam int          S  = int'(QF) - int'(DF) + int'(VF);
  localparam int unsigned SU = (S < 0) ? 0 : S;
  localparam int unsigned NI = DW + SU + 1;
  localparam int unsigned CW = $clog2(NI);
  localparam int unsigned MW = ((NI > QW) ? NI : QW) + 1;

  localparam logic [MW-1:0] LIM  = {{(MW-QW){1'b0}}, 1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};

  if (S < 0) begin : g_bad_format
    $error("fixdiv_seq: QF-DF+VF must be >= 0");
  end

  typedef enum logic [1:0] {st_idle, st_prep, st_iter, st_round} state_t;

  state_t        state_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [NI-1:0] num_q;
  logic [VW-1:0] dmag_q;
  logic [VW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic          dneg_q;
  logic          dz_q;

  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dvs_abs;
  logic [VW:0]   rem_sh;
  logic          ge;
  logic [VW-1:0] diff;
  logic          rnd_inc;
  logic [NI-1:0] mag;
  logic [MW-1:0] magx;
  logic [QW-1:0] res;
  logic          res_ovf;

  assign in_ready = (state_q == st_idle);
  assign busy     = (state_q != st_idle);

  // Two's-complement negate in the native width gives the correct unsigned
  // magnitude even for the most-negative input.
  assign dvd_abs = dvd_q[DW-1] ? -dvd_q : dvd_q;
  assign dvs_abs = dvs_q[VW-1] ? -dvs_q : dvs_q;

  // Remainder stays below the divisor, so the difference fits in VW bits.
  assign rem_sh = {rem_q, num_q[NI-1]};
  assign ge     = (rem_sh >= {1'b0, dmag_q});
  assign diff   = rem_sh[VW-1:0] - dmag_q;

  always_comb begin
    rnd_inc = sign_q ? (num_q[0] & (|rem_q)) : num_q[0];
    mag     = {1'b0, num_q[NI-1:1]} + NI'(rnd_inc);
    magx    = MW'(mag);
    res     = '0;
    res_ovf = 1'b0;
    if (dz_q) begin
      res = dneg_q ? QMIN : QMAX;
    end else if (sign_q) begin
      if (magx > LIM) begin
        res     = QMIN;
        res_ovf = 1'b1;
      end else begin
        res = -magx[QW-1:0];
      end
    end else begin
      if (magx >= LIM) begin
        res     = QMAX;
        res_ovf = 1'b1;
      end else begin
        res = magx[QW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= st_idle;
      out_valid <= 1'b0;
      quotient  <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        st_idle: begin
          if (in_valid) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            state_q <= st_prep;
          end
        end
        st_prep: begin
          sign_q  <= dvd_q[DW-1] ^ dvs_q[VW-1];
          dneg_q  <= dvd_q[DW-1];
          dz_q    <= (dvs_q == '0);
          num_q   <= {dvd_abs, {(SU+1){1'b0}}};
          dmag_q  <= dvs_abs;
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= st_iter;
        end
        st_iter: begin
          // Quotient bits shift in at the bottom as numerator bits leave the top.
          num_q <= {num_q[NI-2:0], ge};
          rem_q <= ge ? diff : rem_sh[VW-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NI-1)) begin
            state_q <= st_round;
          end
        end
        st_round: begin
          quotient  <= res;
          ovf       <= res_ovf;
          dz        <= dz_q;
          out_valid <= 1'b1;
          state_q   <= st_idle;
        end
        default: state_q <= st_idle;
      endcase
    end
  end

endmodule
